// File: rtl/nx1_wb_if.sv
// Wishbone classic-cycle bus between the nx1 initiator and the Neuromorphic X1
// slave port. Signal names are seen from the initiator side (_o driven by the
// master, _i driven by the slave).
//   master modport: drives cyc/stb/we/sel/adr/dat_o, samples dat_i/ack_i
//   slave modport : the mirror image
interface nx1_wb_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/nx1_wb_master.sv
// nx1_wb_master: Wishbone classic-cycle initiator for the Neuromorphic X1 macro.
// Takes one command at a time from a valid/ready stream, runs cmd_len_i+1
// single-beat bus cycles at incrementing word addresses and returns one
// response per beat. A per-beat watchdog aborts a beat the slave never acks,
// and that abort ends the whole command.
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   cmd_*                    command stream (we, byte address, fill data, sel, len)
//   rsp_*                    response stream (read data, timeout error, last flag)
//   wbm                      Wishbone bus (master modport of nx1_wb_if)
//   busy_o                   high whenever a command is in progress
// Every output is a register or a decode of the state register.
module nx1_wb_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LEN_W   = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [31:0]       cmd_adr_i,
  input  logic [31:0]       cmd_dat_i,
  input  logic [3:0]        cmd_sel_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_dat_o,
  output logic              rsp_err_o,
  output logic              rsp_last_o,
  nx1_wb_if.master          wbm,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             live_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      wdog_q, wdog_d;
  logic             err_q, err_d;

  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      rdat_q, rdat_d;

  logic in_idle, in_bus, in_rsp, last;

  assign in_idle = (state_q == S_IDLE);
  assign in_bus  = (state_q == S_BUS);
  assign in_rsp  = (state_q == S_RSP);
  assign last    = (cnt_q == '0) || err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cnt_d   = cmd_len_i;
          wdog_d  = '0;
          err_d   = 1'b0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        wdog_d = wdog_q + 16'd1;
        // An ack on the very cycle the watchdog expires still completes the beat.
        if (wbm.wbm_ack_i) begin
          rdat_d  = we_q ? 32'd0 : wbm.wbm_dat_i;
          state_d = S_RSP;
        end else if (wdog_q == WDOG_LAST) begin
          rdat_d  = 32'd0;
          err_d   = 1'b1;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          if (last) begin
            state_d = S_IDLE;
          end else begin
            adr_d   = adr_q + 32'd4;
            cnt_d   = cnt_q - LEN_W'(1);
            wdog_d  = '0;
            state_d = S_BUS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Datapath holding registers; every output use is qualified by the state.
  always_ff @(posedge wb_clk_i) begin
    we_q   <= we_d;
    adr_q  <= adr_d;
    dat_q  <= dat_d;
    sel_q  <= sel_d;
    rdat_q <= rdat_d;
  end

  // live_q keeps cmd_ready_o low while reset is held, since IDLE is also the
  // reset state.
  assign cmd_ready_o = in_idle && live_q;
  assign busy_o      = !in_idle;

  assign wbm.wbm_cyc_o = in_bus;
  assign wbm.wbm_stb_o = in_bus;
  assign wbm.wbm_we_o  = in_bus && we_q;
  assign wbm.wbm_sel_o = in_bus ? sel_q : 4'd0;
  assign wbm.wbm_adr_o = in_bus ? adr_q : 32'd0;
  assign wbm.wbm_dat_o = in_bus ? dat_q : 32'd0;

  assign rsp_valid_o = in_rsp;
  assign rsp_dat_o   = in_rsp ? rdat_q : 32'd0;
  assign rsp_err_o   = in_rsp && err_q;
  assign rsp_last_o  = in_rsp && last;

endmodule

// File: tb/tb_nx1_wb_master.sv
// Bench for nx1_wb_master: table-driven commands with a response/bus-beat
// scoreboard, plus hand-written backpressure, timeout and reset sequences.
module tb_nx1_wb_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic [4:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;

  nx1_wb_if bus();

  nx1_wb_master #(.TIMEOUT(TO), .LEN_W(5)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .cmd_len_i  (cmd_len),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .rsp_last_o (rsp_last),
    .wbm        (bus),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [4:0]  len;
    int          wt;
    logic        stray;
    int          exp_busy;
    logic [31:0] exp_last_adr;
    logic [31:0] exp_first_dat;
  } vec_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } rsp_t;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } beat_t;

  rsp_t        exp_rsp_q[$];
  beat_t       exp_beat_q[$];
  logic [31:0] beat_log[$];
  logic [31:0] rsp_log[$];

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int cyc_cycles = 0;
  int busy_cycles = 0;
  int rsp_count = 0;

  int slave_wait = 0;
  bit no_ack = 1'b0;
  bit stray_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave model: acks after slave_wait wait states, read data = adr ^ 0xFFFF.
  initial begin
    int    wcnt;
    beat_t eb;
    wcnt = 0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.wbm_ack_i = 1'b0;
        wcnt = 0;
      end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
        if (!no_ack && wcnt == slave_wait) begin
          bus.wbm_ack_i = 1'b1;
          bus.wbm_dat_i = bus.wbm_we_o ? 32'hDEAD_BEEF : (bus.wbm_adr_o ^ 32'h0000_FFFF);
          beat_log.push_back(bus.wbm_adr_o);
          if (exp_beat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got adr %h expected no bus cycle", bus.wbm_adr_o);
          end else begin
            eb = exp_beat_q.pop_front();
            chk("beat_adr", bus.wbm_adr_o, eb.adr);
            chk("beat_we", {31'd0, bus.wbm_we_o}, {31'd0, eb.we});
            chk("beat_sel", {28'd0, bus.wbm_sel_o}, {28'd0, eb.sel});
            if (eb.we) chk("beat_wdat", bus.wbm_dat_o, eb.dat);
          end
          wcnt = 0;
        end else begin
          bus.wbm_ack_i = 1'b0;
          wcnt++;
        end
      end else begin
        bus.wbm_ack_i = stray_ack;
        bus.wbm_dat_i = stray_ack ? 32'h5555_AAAA : 32'd0;
        wcnt = 0;
      end
    end
  end

  // Output monitor: bus activity counters and response scoreboard.
  initial begin
    logic cyc_prev;
    rsp_t er;
    cyc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wbm_cyc_o) cyc_cycles++;
        if (bus.wbm_cyc_o && !cyc_prev) pulses++;
        cyc_prev = bus.wbm_cyc_o;
        if (busy) busy_cycles++;
        if (rsp_valid) chk("rsp_while_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
        if (rsp_valid && rsp_ready) begin
          rsp_count++;
          rsp_log.push_back(rsp_dat);
          if (exp_rsp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got dat %h expected no response", rsp_dat);
          end else begin
            er = exp_rsp_q.pop_front();
            chk("rsp_dat", rsp_dat, er.dat);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, er.err});
            chk("rsp_last", {31'd0, rsp_last}, {31'd0, er.last});
          end
        end
      end else begin
        cyc_prev = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic push_exp(input vec_t v);
    logic [31:0] a;
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.adr + 32'(4 * i);
      exp_beat_q.push_back('{adr: a, we: v.we, dat: v.dat, sel: v.sel});
      exp_rsp_q.push_back('{dat: (v.we ? 32'd0 : (a ^ 32'h0000_FFFF)), err: 1'b0,
                            last: (i == int'(v.len))});
    end
  endtask

  task automatic send(input vec_t v);
    bit got;
    @(posedge clk); #1;
    cmd_we = v.we;
    cmd_adr = v.adr;
    cmd_dat = v.dat;
    cmd_sel = v.sel;
    cmd_len = v.len;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("cmd_accepted", {31'd0, got}, 32'd1);
    chk("cyc_after_cmd", {31'd0, bus.wbm_cyc_o}, 32'd1);
    chk("ready_low_busy", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic run_cmd(input vec_t v);
    int p0, c0, b0, r0;
    logic [31:0] first;
    push_exp(v);
    slave_wait = v.wt;
    stray_ack = v.stray;
    p0 = pulses; c0 = cyc_cycles; b0 = busy_cycles; r0 = rsp_count;
    send(v);
    wait_idle(500);
    stray_ack = 1'b0;
    first = (rsp_log.size() > r0) ? rsp_log[r0] : 32'hxxxx_xxxx;
    chk("pulse_count", 32'(pulses - p0), 32'(int'(v.len) + 1));
    chk("cyc_width_total", 32'(cyc_cycles - c0), 32'((int'(v.len) + 1) * (v.wt + 1)));
    chk("busy_cycles", 32'(busy_cycles - b0), 32'(v.exp_busy));
    chk("rsp_count", 32'(rsp_count - r0), 32'(int'(v.len) + 1));
    chk("last_beat_adr", (beat_log.size() > 0) ? beat_log[$] : 32'hxxxx_xxxx, v.exp_last_adr);
    chk("first_rsp_dat", first, v.exp_first_dat);
    chk("beat_q_drained", 32'(exp_beat_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(exp_rsp_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int p0, c0, r0;
    bit got;
    logic [31:0] sd;
    logic se, sl;

    vecs[0] = '{we: 1'b1, adr: 32'h3000_0000, dat: 32'hA5A5_0001, sel: 4'hF, len: 5'd0, wt: 1,
                stray: 1'b0, exp_busy: 3, exp_last_adr: 32'h3000_0000, exp_first_dat: 32'h0};
    vecs[1] = '{we: 1'b0, adr: 32'h3000_0010, dat: 32'h0, sel: 4'hF, len: 5'd3, wt: 0,
                stray: 1'b0, exp_busy: 8, exp_last_adr: 32'h3000_001C, exp_first_dat: 32'h3000_FFEF};
    vecs[2] = '{we: 1'b1, adr: 32'hFFFF_FFFC, dat: 32'h0BAD_F00D, sel: 4'h3, len: 5'd1, wt: 2,
                stray: 1'b1, exp_busy: 8, exp_last_adr: 32'h0000_0000, exp_first_dat: 32'h0};
    vecs[3] = '{we: 1'b0, adr: 32'h0000_0100, dat: 32'h0, sel: 4'hF, len: 5'd0, wt: 0,
                stray: 1'b0, exp_busy: 2, exp_last_adr: 32'h0000_0100, exp_first_dat: 32'h0000_FEFF};
    vecs[4] = '{we: 1'b0, adr: 32'h1234_5678, dat: 32'h0, sel: 4'hC, len: 5'd31, wt: 0,
                stray: 1'b0, exp_busy: 64, exp_last_adr: 32'h1234_56F4, exp_first_dat: 32'h1234_A987};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus.wbm_stb_o}, 32'd0);
    chk("rst_we", {31'd0, bus.wbm_we_o}, 32'd0);
    chk("rst_sel", {28'd0, bus.wbm_sel_o}, 32'd0);
    chk("rst_adr", bus.wbm_adr_o, 32'd0);
    chk("rst_wdat", bus.wbm_dat_o, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Stray acks while idle
    stray_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_idle_busy", {31'd0, busy}, 32'd0);
    chk("stray_idle_rsp", {31'd0, rsp_valid}, 32'd0);
    stray_ack = 1'b0;

    for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

    // Backpressure on the first read response
    v = '{we: 1'b0, adr: 32'h3000_0200, dat: 32'h0, sel: 4'hF, len: 5'd1, wt: 0,
          stray: 1'b0, exp_busy: 0, exp_last_adr: 32'h0, exp_first_dat: 32'h0};
    push_exp(v);
    slave_wait = 0;
    rsp_ready = 1'b0;
    p0 = pulses;
    send(v);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("bp_rsp_seen", {31'd0, got}, 32'd1);
    sd = rsp_dat; se = rsp_err; sl = rsp_last;
    chk("bp_dat", sd, 32'h3000_FDFF);
    chk("bp_last", {31'd0, sl}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("bp_dat_stable", rsp_dat, sd);
      chk("bp_err_stable", {31'd0, rsp_err}, {31'd0, se});
      chk("bp_last_stable", {31'd0, rsp_last}, {31'd0, sl});
      chk("bp_no_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    end
    chk("bp_pulses_stalled", 32'(pulses - p0), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next_cyc", {31'd0, bus.wbm_cyc_o}, 32'd1);
    chk("bp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
    wait_idle(100);
    chk("bp_pulses_total", 32'(pulses - p0), 32'd2);
    chk("bp_rsp_q_drained", 32'(exp_rsp_q.size()), 32'd0);

    // Timeout: slave never acks, remaining beats abandoned
    v = '{we: 1'b0, adr: 32'h3000_0040, dat: 32'h0, sel: 4'hF, len: 5'd2, wt: 0,
          stray: 1'b0, exp_busy: 0, exp_last_adr: 32'h0, exp_first_dat: 32'h0};
    exp_rsp_q.push_back('{dat: 32'd0, err: 1'b1, last: 1'b1});
    no_ack = 1'b1;
    p0 = pulses; c0 = cyc_cycles; r0 = rsp_count;
    send(v);
    wait_idle(100);
    repeat (10) @(posedge clk);
    #1;
    chk("to_cyc_width", 32'(cyc_cycles - c0), 32'(TO));
    chk("to_pulses", 32'(pulses - p0), 32'd1);
    chk("to_rsp_count", 32'(rsp_count - r0), 32'd1);
    chk("to_ready_back", {31'd0, cmd_ready}, 32'd1);
    no_ack = 1'b0;

    // Asynchronous reset in the middle of beat 2 of a 5-beat read
    v = '{we: 1'b0, adr: 32'h3000_0080, dat: 32'h0, sel: 4'hF, len: 5'd4, wt: 1,
          stray: 1'b0, exp_busy: 0, exp_last_adr: 32'h0, exp_first_dat: 32'h0};
    push_exp(v);
    slave_wait = 1;
    p0 = pulses;
    send(v);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pulses - p0 == 2) begin
        got = 1'b1;
        break;
      end
    end
    chk("rr_beat2_reached", {31'd0, got}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_cyc_drop", {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("rr_stb_drop", {31'd0, bus.wbm_stb_o}, 32'd0);
    chk("rr_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("rr_busy_drop", {31'd0, busy}, 32'd0);
    chk("rr_ready_low", {31'd0, cmd_ready}, 32'd0);
    chk("rr_adr_zero", bus.wbm_adr_o, 32'd0);
    exp_rsp_q.delete();
    exp_beat_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v = '{we: 1'b0, adr: 32'h3000_0300, dat: 32'h0, sel: 4'hF, len: 5'd0, wt: 1,
          stray: 1'b0, exp_busy: 3, exp_last_adr: 32'h3000_0300, exp_first_dat: 32'h3000_FCFF};
    run_cmd(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
